// File: rtl/lector_contadores.sv
// Counter-bank reader: on start, waits for idle, reads the N_CNT output-word counters
// one per cycle, sums them and compares the total against the expected word count.
module lector_contadores #(
  parameter int DATA_W = 5,
  parameter int N_CNT  = 4,
  parameter int IDX_W  = 2,
  parameter int SUM_W  = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              idle,
  input  logic [DATA_W-1:0] data_in,
  input  logic              valid_in,
  input  logic [SUM_W-1:0]  esperado,
  output logic              req,
  output logic [IDX_W-1:0]  idx,
  output logic [DATA_W-1:0] cnt_0,
  output logic [DATA_W-1:0] cnt_1,
  output logic [DATA_W-1:0] cnt_2,
  output logic [DATA_W-1:0] cnt_3,
  output logic [SUM_W-1:0]  total,
  output logic              busy,
  output logic              done,
  output logic              match
);

  typedef enum logic [1:0] {REPOSO, WAIT_IDLE, LECTURA, FIN} state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CNT - 1);

  state_t            state_reg;
  logic [IDX_W-1:0]  ptr_reg;
  logic [DATA_W-1:0] cnt_reg [N_CNT];
  logic [SUM_W-1:0]  total_reg;
  logic [SUM_W-1:0]  esperado_q;
  logic              match_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= REPOSO;
      ptr_reg    <= '0;
      total_reg  <= '0;
      esperado_q <= '0;
      match_reg  <= 1'b0;
      for (int i = 0; i < N_CNT; i++) cnt_reg[i] <= '0;
    end else begin
      case (state_reg)
        REPOSO: begin
          // Results of the previous sweep stay visible until a new sweep is accepted.
          if (start) begin
            state_reg  <= WAIT_IDLE;
            ptr_reg    <= '0;
            total_reg  <= '0;
            esperado_q <= esperado;
            match_reg  <= 1'b0;
            for (int i = 0; i < N_CNT; i++) cnt_reg[i] <= '0;
          end
        end
        WAIT_IDLE: begin
          if (idle) state_reg <= LECTURA;
        end
        LECTURA: begin
          // A read that the bank does not validate is simply retried on the same index.
          if (valid_in) begin
            cnt_reg[ptr_reg] <= data_in;
            total_reg        <= total_reg + SUM_W'(data_in);
            if (ptr_reg == LAST_IDX) state_reg <= FIN;
            else                     ptr_reg   <= ptr_reg + IDX_W'(1);
          end
        end
        FIN: begin
          match_reg <= (total_reg == esperado_q);
          state_reg <= REPOSO;
        end
        default: state_reg <= REPOSO;
      endcase
    end
  end

  assign req   = (state_reg == LECTURA);
  assign idx   = ptr_reg;
  assign busy  = (state_reg != REPOSO);
  assign done  = (state_reg == FIN);
  assign total = total_reg;
  assign match = match_reg;
  assign cnt_0 = cnt_reg[0];
  assign cnt_1 = cnt_reg[1];
  assign cnt_2 = cnt_reg[2];
  assign cnt_3 = cnt_reg[3];

endmodule

// File: tb/tb_lector_contadores.sv
// Directed bench for lector_contadores with a small combinational counter-bank model.
module tb_lector_contadores;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       idle;
  logic [4:0] data_in;
  logic       valid_in;
  logic [6:0] esperado;
  logic       req;
  logic [1:0] idx;
  logic [4:0] cnt_0, cnt_1, cnt_2, cnt_3;
  logic [6:0] total;
  logic       busy, done, match;

  logic [4:0] bank [4];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Counter bank: a read is valid only while requested and idle; otherwise it returns junk.
  assign valid_in = req && idle;
  assign data_in  = valid_in ? bank[idx] : 5'd17;

  lector_contadores dut (
    .clk(clk), .rst(rst), .start(start), .idle(idle),
    .data_in(data_in), .valid_in(valid_in), .esperado(esperado),
    .req(req), .idx(idx),
    .cnt_0(cnt_0), .cnt_1(cnt_1), .cnt_2(cnt_2), .cnt_3(cnt_3),
    .total(total), .busy(busy), .done(done), .match(match)
  );

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full sweep. c counts edges since the start-accept edge; samples are 1 ns after each edge.
  task automatic sweep(input string name, input logic [6:0] esp, input int wait_c,
                       input bit drop, input bit repulse, input int exp_done_c,
                       input int exp_req, input int exp_total, input int exp_match);
    int c = 0, done_c = -1, n_done = 0, n_req = 0, seq = 0, dcnt = 0;
    bit dropped = 1'b0;
    esperado = esp;
    idle     = (wait_c == 0);
    start    = 1'b1;
    step();
    start    = 1'b0;
    esperado = 7'h55;
    check({name, " busy after accept"}, int'(busy), 1);
    while (c < 60 && (done_c < 0 || c < done_c + 4)) begin
      if (wait_c > 0 && c >= wait_c) idle = 1'b1;
      if (drop && req && idx == 2'd2 && !dropped) begin
        idle = 1'b0; dcnt = 3; dropped = 1'b1;
      end else if (dcnt > 0) begin
        dcnt--;
        if (dcnt == 0) idle = 1'b1;
      end
      if (wait_c > 0 && c < wait_c) check({name, " req low while waiting"}, int'(req), 0);
      if (req) n_req++;
      if (req && idle) seq = seq * 4 + int'(idx);
      if (done) begin
        n_done++;
        if (done_c < 0) done_c = c;
      end
      start = repulse && (c == 2);
      step();
      c++;
    end
    start = 1'b0;
    idle  = 1'b1;
    $display("sweep %s: done at +%0d, req cycles %0d, total %0d, match %0d",
             name, done_c, n_req, total, match);
    check({name, " done latency"}, done_c, exp_done_c);
    check({name, " done pulses"}, n_done, 1);
    check({name, " req cycles"}, n_req, exp_req);
    check({name, " idx order"}, seq, 27);
    check({name, " cnt_0"}, int'(cnt_0), int'(bank[0]));
    check({name, " cnt_1"}, int'(cnt_1), int'(bank[1]));
    check({name, " cnt_2"}, int'(cnt_2), int'(bank[2]));
    check({name, " cnt_3"}, int'(cnt_3), int'(bank[3]));
    check({name, " total"}, int'(total), exp_total);
    check({name, " match"}, int'(match), exp_match);
    check({name, " busy idle"}, int'(busy), 0);
  endtask

  task automatic check_cleared(input string name);
    check({name, " busy"}, int'(busy), 0);
    check({name, " req"}, int'(req), 0);
    check({name, " idx"}, int'(idx), 0);
    check({name, " done"}, int'(done), 0);
    check({name, " cnt_0"}, int'(cnt_0), 0);
    check({name, " cnt_1"}, int'(cnt_1), 0);
    check({name, " cnt_2"}, int'(cnt_2), 0);
    check({name, " cnt_3"}, int'(cnt_3), 0);
    check({name, " total"}, int'(total), 0);
    check({name, " match"}, int'(match), 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; idle = 1'b1; esperado = '0;
    bank[0] = 5'd3; bank[1] = 5'd0; bank[2] = 5'd7; bank[3] = 5'd1;
    step(); step();
    rst = 1'b0;
    check_cleared("reset");
    $display("reset: busy %0d total %0d", busy, total);

    sweep("basic",  7'd11, 0, 1'b0, 1'b0, 5, 4, 11, 1);
    sweep("nomatch", 7'd12, 0, 1'b0, 1'b0, 5, 4, 11, 0);
    sweep("waitidle", 7'd11, 6, 1'b0, 1'b0, 11, 4, 11, 1);
    sweep("drop", 7'd11, 0, 1'b1, 1'b0, 8, 7, 11, 1);

    bank[0] = 5'd31; bank[1] = 5'd31; bank[2] = 5'd31; bank[3] = 5'd31;
    sweep("allmax", 7'd124, 0, 1'b0, 1'b1, 5, 4, 124, 1);

    // Abort a sweep with reset while the second counter is being read.
    bank[0] = 5'd3; bank[1] = 5'd0; bank[2] = 5'd7; bank[3] = 5'd1;
    esperado = 7'd11; idle = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    step(); step();
    check("midreset idx before", int'(idx), 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_cleared("midreset");
    $display("midreset: busy %0d total %0d", busy, total);
    for (int i = 0; i < 6; i++) begin
      check("midreset no done", int'(done), 0);
      step();
    end
    sweep("afterreset", 7'd11, 0, 1'b0, 1'b0, 5, 4, 11, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
